// File: rtl/friscv_pkg.sv
// Shared RV32I definitions: datapath width and the ALU opcode encoding.
package friscv_pkg;

    localparam int ARCH       = 32;
    localparam int SHAMT_W    = $clog2(ARCH);
    localparam int ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SAR  = 4'd7,
        ALU_SLR  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

endpackage

// File: rtl/alu.sv
// RV32I integer ALU, purely combinational. Unknown opcodes yield zero.
module alu
    import friscv_pkg::*;
(
    input  logic [ALU_CTRL_W-1:0] ctrl_in,
    input  logic [ARCH-1:0]       a_in,
    input  logic [ARCH-1:0]       b_in,
    output logic [ARCH-1:0]       result_out,
    output logic                  zero_out
);

    logic [SHAMT_W-1:0] shamt;

    assign shamt = b_in[SHAMT_W-1:0];

    always_comb begin
        // NOTE: default assigned first so no path through the case infers a latch.
        result_out = '0;
        case (ctrl_in)
            ALU_AND:  result_out = a_in & b_in;
            ALU_OR:   result_out = a_in | b_in;
            ALU_XOR:  result_out = a_in ^ b_in;
            ALU_ADD:  result_out = a_in + b_in;
            ALU_SUB:  result_out = a_in - b_in;
            ALU_SLT:  result_out = ARCH'($signed(a_in) < $signed(b_in));
            ALU_SLL:  result_out = a_in << shamt;
            ALU_SAR:  result_out = ARCH'($signed(a_in) >>> shamt);
            ALU_SLR:  result_out = a_in >> shamt;
            ALU_SLTU: result_out = ARCH'(a_in < b_in);
            default:  result_out = '0;
        endcase
    end

    assign zero_out = (result_out == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1, wrapping.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_in,
    input  logic [ID_W-1:0] ptr_in,
    output logic [N-1:0]    grant_out,
    output logic [ID_W-1:0] grant_id_out,
    output logic            grant_any_out
);

    always_comb begin
        grant_out     = '0;
        grant_id_out  = '0;
        grant_any_out = 1'b0;
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = int'(ptr_in) + i;
            if (idx >= N) idx = idx - N;
            if (!grant_any_out && req_in[idx]) begin
                grant_any_out  = 1'b1;
                grant_out[idx] = 1'b1;
                grant_id_out   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ valid/ready requesters through a registered
// one-deep output slot that refills in the same cycle it drains.
module alu_arbiter
    import friscv_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    input  logic [NUM_REQ*ALU_CTRL_W-1:0] req_ctrl_in,
    input  logic [NUM_REQ*ARCH-1:0]       req_a_in,
    input  logic [NUM_REQ*ARCH-1:0]       req_b_in,
    output logic [NUM_REQ-1:0]            rsp_valid_out,
    input  logic [NUM_REQ-1:0]            rsp_ready_in,
    output logic [ARCH-1:0]               rsp_result_out,
    output logic                          rsp_zero_out,
    output logic                          busy_out
);

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;

    slot_state_e         state_q, state_d;
    logic [ID_W-1:0]     owner_q, ptr_q, grant_id;
    logic [NUM_REQ-1:0]  grant;
    logic                grant_any, slot_valid, drain, can_accept;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [ARCH-1:0]     alu_a, alu_b, alu_result, result_q;
    logic                alu_zero, zero_q;

    assign slot_valid = (state_q == SLOT_FULL);
    assign drain      = slot_valid & rsp_ready_in[owner_q];
    assign can_accept = !slot_valid | drain;

    rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req_in        (req_valid_in & {NUM_REQ{can_accept}}),
        .ptr_in        (ptr_q),
        .grant_out     (grant),
        .grant_id_out  (grant_id),
        .grant_any_out (grant_any)
    );

    assign req_ready_out = grant;

    // With no grant the mux still selects requester 0; the ALU output is then unused.
    assign alu_ctrl = req_ctrl_in[grant_id*ALU_CTRL_W +: ALU_CTRL_W];
    assign alu_a    = req_a_in[grant_id*ARCH +: ARCH];
    assign alu_b    = req_b_in[grant_id*ARCH +: ARCH];

    alu u_alu (
        .ctrl_in    (alu_ctrl),
        .a_in       (alu_a),
        .b_in       (alu_b),
        .result_out (alu_result),
        .zero_out   (alu_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (grant_any) state_d = SLOT_FULL;
            SLOT_FULL:  if (drain && !grant_any) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= SLOT_EMPTY;
            result_q <= '0;
            zero_q   <= 1'b0;
            owner_q  <= '0;
            ptr_q    <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
                owner_q  <= grant_id;
                ptr_q    <= grant_id;
            end
        end
    end

    always_comb begin
        rsp_valid_out = '0;
        if (slot_valid) rsp_valid_out[owner_q] = 1'b1;
    end

    assign rsp_result_out = result_q;
    assign rsp_zero_out   = zero_q;
    assign busy_out       = slot_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with two requesters.
module tb_alu_arbiter;
    import friscv_pkg::*;

    localparam int NUM_REQ = 2;

    logic                          clk_i = 1'b0;
    logic                          rst_n_i;
    logic [NUM_REQ-1:0]            req_valid_in;
    logic [NUM_REQ-1:0]            req_ready_out;
    logic [NUM_REQ*ALU_CTRL_W-1:0] req_ctrl_in;
    logic [NUM_REQ*ARCH-1:0]       req_a_in;
    logic [NUM_REQ*ARCH-1:0]       req_b_in;
    logic [NUM_REQ-1:0]            rsp_valid_out;
    logic [NUM_REQ-1:0]            rsp_ready_in;
    logic [ARCH-1:0]               rsp_result_out;
    logic                          rsp_zero_out;
    logic                          busy_out;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_ctrl_in    (req_ctrl_in),
        .req_a_in       (req_a_in),
        .req_b_in       (req_b_in),
        .rsp_valid_out  (rsp_valid_out),
        .rsp_ready_in   (rsp_ready_in),
        .rsp_result_out (rsp_result_out),
        .rsp_zero_out   (rsp_zero_out),
        .busy_out       (busy_out)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int idx, input logic v, input logic [ALU_CTRL_W-1:0] op,
                           input logic [ARCH-1:0] a, input logic [ARCH-1:0] b);
        req_valid_in[idx]                        = v;
        req_ctrl_in[idx*ALU_CTRL_W +: ALU_CTRL_W] = op;
        req_a_in[idx*ARCH +: ARCH]                = a;
        req_b_in[idx*ARCH +: ARCH]                = b;
    endtask

    task automatic pulse_reset();
        rst_n_i = 1'b0;
        #1;
        rst_n_i = 1'b1;
    endtask

    initial begin
        rst_n_i      = 1'b0;
        req_valid_in = '0;
        req_ctrl_in  = '0;
        req_a_in     = '0;
        req_b_in     = '0;
        rsp_ready_in = '0;
        #2;
        check("reset_rsp_valid", 32'(rsp_valid_out), 32'h0);
        check("reset_result", rsp_result_out, 32'h0);
        check("reset_zero", 32'(rsp_zero_out), 32'h0);
        check("reset_busy", 32'(busy_out), 32'h0);
        check("reset_ready", 32'(req_ready_out), 32'h0);
        step();
        rst_n_i = 1'b1;

        // 1: single ADD from requester 0
        rsp_ready_in = 2'b11;
        set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
        #1;
        check("t1_ready", 32'(req_ready_out), 32'h1);
        step();
        set_req(0, 1'b0, ALU_ADD, 32'd5, 32'd7);
        check("t1_rsp_valid", 32'(rsp_valid_out), 32'h1);
        check("t1_result", rsp_result_out, 32'd12);
        check("t1_zero", 32'(rsp_zero_out), 32'h0);
        check("t1_busy", 32'(busy_out), 32'h1);
        step();
        check("t1_drained", 32'(busy_out), 32'h0);
        check("t1_result_hold", rsp_result_out, 32'd12);

        // 2: both requesters every cycle, full throughput, alternating grants
        pulse_reset();
        set_req(0, 1'b1, ALU_SUB, 32'd3, 32'd3);
        set_req(1, 1'b1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_ready", 32'(req_ready_out), (k % 2 == 0) ? 32'h1 : 32'h2);
            step();
            check("t2_rsp_valid", 32'(rsp_valid_out), (k % 2 == 0) ? 32'h1 : 32'h2);
            check("t2_result", rsp_result_out, (k % 2 == 0) ? 32'h0 : 32'hFF);
            check("t2_zero", 32'(rsp_zero_out), (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        req_valid_in = '0;
        step();
        check("t2_drained", 32'(busy_out), 32'h0);

        // 3: backpressure on requester 1; non-owner ready must be ignored
        set_req(1, 1'b1, ALU_SLL, 32'd1, 32'd4);
        #1;
        check("t3_ready1", 32'(req_ready_out), 32'h2);
        step();
        set_req(1, 1'b0, ALU_SLL, 32'd1, 32'd4);
        set_req(0, 1'b1, ALU_ADD, 32'd2, 32'd3);
        rsp_ready_in = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3_hold_valid", 32'(rsp_valid_out), 32'h2);
            check("t3_hold_result", rsp_result_out, 32'd16);
            check("t3_blocked", 32'(req_ready_out), 32'h0);
            step();
        end
        rsp_ready_in = 2'b10;
        #1;
        check("t3_same_cycle_grant", 32'(req_ready_out), 32'h1);
        step();
        check("t3_rsp_valid0", 32'(rsp_valid_out), 32'h1);
        check("t3_result0", rsp_result_out, 32'd5);
        req_valid_in = '0;
        rsp_ready_in = 2'b11;
        step();
        check("t3_drained", 32'(busy_out), 32'h0);

        // 4: signed vs unsigned compare, arithmetic shift
        set_req(0, 1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        #1;
        check("t4_slt_ready", 32'(req_ready_out), 32'h1);
        step();
        check("t4_slt", rsp_result_out, 32'd1);
        set_req(0, 1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
        step();
        check("t4_sltu", rsp_result_out, 32'd0);
        check("t4_sltu_zero", 32'(rsp_zero_out), 32'h1);
        set_req(0, 1'b1, ALU_SAR, 32'h8000_0000, 32'd31);
        step();
        check("t4_sar", rsp_result_out, 32'hFFFF_FFFF);
        check("t4_sar_valid", 32'(rsp_valid_out), 32'h1);
        req_valid_in = '0;
        step();

        // 5: reset while FULL clears the slot immediately
        rsp_ready_in = 2'b00;
        set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
        step();
        req_valid_in = '0;
        check("t5_full", 32'(busy_out), 32'h1);
        rst_n_i = 1'b0;
        #1;
        check("t5_rst_valid", 32'(rsp_valid_out), 32'h0);
        check("t5_rst_busy", 32'(busy_out), 32'h0);
        check("t5_rst_result", rsp_result_out, 32'h0);
        rst_n_i = 1'b1;
        rsp_ready_in = 2'b11;
        set_req(0, 1'b1, ALU_XOR, 32'h0000_00FF, 32'h0000_000F);
        set_req(1, 1'b1, ALU_AND, 32'h0000_00FF, 32'h0000_000F);
        #1;
        check("t5_first_grant", 32'(req_ready_out), 32'h1);
        step();
        check("t5_rsp_valid", 32'(rsp_valid_out), 32'h1);
        check("t5_result", rsp_result_out, 32'h0000_00F0);

        // 6: unknown opcode behaves as a normal op returning zero
        set_req(0, 1'b0, ALU_XOR, 32'd0, 32'd0);
        set_req(1, 1'b1, 4'hF, 32'd9, 32'd9);
        #1;
        check("t6_ready", 32'(req_ready_out), 32'h2);
        step();
        req_valid_in = '0;
        check("t6_rsp_valid", 32'(rsp_valid_out), 32'h2);
        check("t6_result", rsp_result_out, 32'h0);
        check("t6_zero", 32'(rsp_zero_out), 32'h1);
        step();
        check("t6_drained", 32'(busy_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
